// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART transmit path
package uart_pkg;

  localparam int UART_DATA_WIDTH = 32;
  localparam int UART_CNT_W      = $clog2(UART_DATA_WIDTH);

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame serializer: start, data LSB-first, parity, stop; one bit per baud clock
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  CLK_Baudin,
  input  logic                  RstTx,
  input  logic                  NewData,
  input  logic                  Flag_in,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic                  TransmittedSerialData,
  output logic                  DoneTx
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  line_q, line_d;
  logic                  done_q, done_d;

  // line_d is the level the line takes for the state being entered, so every output is a flop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    line_d  = line_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        line_d = IDLE_LVL;
        if (NewData) begin
          shift_d = DataIn;
          par_d   = (^DataIn) ^ Flag_in;
          line_d  = START_LVL;
          state_d = S_START;
        end
      end
      S_START: begin
        line_d  = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == LAST_BIT) begin
          line_d  = par_q;
          state_d = S_PARITY;
        end else begin
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        line_d  = IDLE_LVL;
        done_d  = 1'b1;
        state_d = S_STOP;
      end
      S_STOP: begin
        line_d  = IDLE_LVL;
        state_d = S_IDLE;
      end
      default: begin
        line_d  = IDLE_LVL;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_Baudin) begin
    if (RstTx) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= IDLE_LVL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  assign TransmittedSerialData = line_q;
  assign DoneTx                = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-level model
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_data;
  logic        flag;
  logic [31:0] data_in;
  logic        line;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx dut (
    .CLK_Baudin           (clk),
    .RstTx                (rst),
    .NewData              (new_data),
    .Flag_in              (flag),
    .DataIn               (data_in),
    .TransmittedSerialData(line),
    .DoneTx               (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Parity bit from the frame rules: even parity makes the total ones count even
  function automatic logic model_parity(input logic [31:0] d, input logic odd);
    return logic'(($countones(d) + (odd ? 1 : 0)) % 2);
  endfunction

  // Sends one frame and checks it bit-by-bit from the serial line against the model.
  task automatic send_frame(input string tag, input logic [31:0] d, input logic odd,
                            input bit repulse, input bit hold);
    logic [31:0] got;
    logic        start_got, par_got, stop_got, done_stop;
    int          dones;
    int          lows;
    data_in  = d;
    flag     = odd;
    new_data = 1'b1;
    tick();
    if (!hold) new_data = 1'b0;
    data_in   = $urandom;
    flag      = 1'($urandom_range(0, 1));
    start_got = line;
    dones     = int'(done);
    for (int i = 0; i < 32; i++) begin
      tick();
      got[i] = line;
      dones += int'(done);
      if (repulse && i == 8) begin
        new_data = 1'b1;
        data_in  = ~d;
      end else if (repulse && i == 9) begin
        new_data = 1'b0;
      end
    end
    tick();
    par_got = line;
    dones  += int'(done);
    tick();
    stop_got  = line;
    done_stop = done;
    dones    += int'(done);
    check({tag, " start"}, 32'(start_got), 32'(START_BIT));
    check({tag, " data"}, got, d);
    check({tag, " parity"}, 32'(par_got), 32'(model_parity(d, odd)));
    check({tag, " stop"}, 32'(stop_got), 32'd1);
    check({tag, " done_in_stop"}, 32'(done_stop), 32'd1);
    check({tag, " done_count"}, 32'(dones), 32'd1);
    tick();
    check({tag, " idle_done"}, 32'(done), 32'd0);
    check({tag, " idle_line"}, 32'(line), 32'd1);
    if (hold) begin
      tick();
      check({tag, " hold_restart"}, 32'(line), 32'd0);
    end else begin
      lows = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        lows += (line == 1'b0) ? 1 : 0;
      end
      check({tag, " no_extra_frame"}, 32'(lows), 32'd0);
    end
  endtask

  localparam logic START_BIT = 1'b0;

  initial begin
    int lows;
    int dones;
    rst      = 1'b1;
    new_data = 1'b0;
    flag     = 1'b0;
    data_in  = '0;

    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset line", 32'(line), 32'd1);
      check("reset done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    tick();
    check("post-reset line", 32'(line), 32'd1);
    check("post-reset done", 32'(done), 32'd0);

    send_frame("a5a5f0f0 even", 32'hA5A5F0F0, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    send_frame("deadbeef odd", 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    send_frame("repulse", 32'h1234_5678, 1'b0, 1'b1, 1'b0);

    // Abort mid-DATA: line must go high on the reset edge and no completion follows
    data_in  = 32'h0F0F_0000;
    flag     = 1'b0;
    new_data = 1'b1;
    tick();
    new_data = 1'b0;
    repeat (12) tick();
    rst = 1'b1;
    tick();
    check("abort line", 32'(line), 32'd1);
    check("abort done", 32'(done), 32'd0);
    rst   = 1'b0;
    lows  = 0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lows  += (line == 1'b0) ? 1 : 0;
      dones += int'(done);
    end
    check("abort quiet line", 32'(lows), 32'd0);
    check("abort no done", 32'(dones), 32'd0);
    send_frame("after abort", 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);

    send_frame("zero even", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    send_frame("zero odd", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send_frame("ones even", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    send_frame("ones odd", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      send_frame($sformatf("rand%0d", k), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // NewData held high: second frame begins on the first IDLE edge after STOP
    send_frame("hold", 32'h8000_0001, 1'b1, 1'b0, 1'b1);
    new_data = 1'b0;
    rst      = 1'b1;
    tick();
    check("hold cleanup line", 32'(line), 32'd1);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
